// File: rtl/cache_pkg.sv
// Shared cache constants, the cache line type, and the burst adaptor state encoding.
package cache_pkg;

    localparam int LINE_W = 256;
    localparam int BEAT_W = 64;
    localparam int BEATS  = LINE_W / BEAT_W;
    localparam int OFF_W  = $clog2(LINE_W / 8);

    typedef logic [LINE_W-1:0] cacheline_t;

    typedef enum logic [1:0] {
        IDLE,
        RD_BURST,
        WR_BURST,
        DONE
    } adaptor_state_t;

endpackage

// File: rtl/cacheline_burst_adaptor_if.sv
// Cache-side request/response and memory-side burst signals of the line adaptor.
// The slave modport is the adaptor's view; the master modport is the cache/memory view.
interface cacheline_burst_adaptor_if #(
    parameter int LINE_W = cache_pkg::LINE_W,
    parameter int BEAT_W = cache_pkg::BEAT_W,
    parameter int ADDR_W = 32
);

    logic [LINE_W-1:0] line_i;
    logic [ADDR_W-1:0] address_i;
    logic              read_i;
    logic              write_i;
    logic [LINE_W-1:0] line_o;
    logic              resp_o;
    logic [BEAT_W-1:0] burst_i;
    logic [BEAT_W-1:0] burst_o;
    logic [ADDR_W-1:0] address_o;
    logic              read_o;
    logic              write_o;
    logic              resp_i;

    modport slave (
        input  line_i, address_i, read_i, write_i, burst_i, resp_i,
        output line_o, resp_o, burst_o, address_o, read_o, write_o
    );

    modport master (
        output line_i, address_i, read_i, write_i, burst_i, resp_i,
        input  line_o, resp_o, burst_o, address_o, read_o, write_o
    );

endinterface

// File: rtl/cacheline_burst_adaptor_line_beat_buffer.sv
// Line register split into beat slots: per-slot beat write for fills, full-line load
// for write-backs, and a slot read mux for the outgoing beat.
module line_beat_buffer #(
    parameter int LINE_W = 256,
    parameter int BEAT_W = 64,
    parameter int CNT_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [LINE_W-1:0] line_i,
    input  logic              beat_we_i,
    input  logic [CNT_W-1:0]  slot_i,
    input  logic [BEAT_W-1:0] beat_i,
    output logic [LINE_W-1:0] line_o,
    output logic [BEAT_W-1:0] beat_o
);

    localparam int BEATS = LINE_W / BEAT_W;

    logic [BEAT_W-1:0] slot_q [BEATS];
    logic [BEAT_W-1:0] slot_d [BEATS];

    for (genvar gi = 0; gi < BEATS; gi++) begin : g_slot
        // A full-line load always wins; a beat write only touches its own slot.
        assign slot_d[gi] = load_i ? line_i[gi*BEAT_W +: BEAT_W] :
                            (beat_we_i && (slot_i == CNT_W'(gi))) ? beat_i :
                            slot_q[gi];
        assign line_o[gi*BEAT_W +: BEAT_W] = slot_q[gi];
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < BEATS; i++) begin
            if (rst) begin
                slot_q[i] <= '0;
            end else begin
                slot_q[i] <= slot_d[i];
            end
        end
    end

    assign beat_o = slot_q[slot_i];

endmodule

// File: rtl/cacheline_burst_adaptor.sv
// Cache line <-> memory burst adaptor: serialises write-back lines into beats and
// assembles fill beats into a line. Optional perf counters under CACHELINE_ADAPTOR_PERF_EN.
module cacheline_burst_adaptor #(
    parameter int LINE_W = cache_pkg::LINE_W,
    parameter int BEAT_W = cache_pkg::BEAT_W,
    parameter int ADDR_W = 32
) (
    input  logic clk,
    input  logic rst,
    cacheline_burst_adaptor_if.slave bus
`ifdef CACHELINE_ADAPTOR_PERF_EN
    ,
    output logic [31:0] fill_count_o,
    output logic [31:0] wb_count_o
`endif
);

    localparam int BEATS = LINE_W / BEAT_W;
    localparam int OFF_W = $clog2(LINE_W / 8);
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef cache_pkg::adaptor_state_t state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              load_line;
    logic              beat_we;
    logic [BEAT_W-1:0] slot_beat;
    logic [ADDR_W-1:0] aligned_addr;
    logic              unused_addr_bits;

    assign aligned_addr     = {bus.address_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign unused_addr_bits = ^bus.address_i[OFF_W-1:0];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        load_line = 1'b0;
        beat_we   = 1'b0;
        unique case (state_q)
            cache_pkg::IDLE: begin
                if (bus.write_i) begin
                    addr_d    = aligned_addr;
                    load_line = 1'b1;
                    cnt_d     = '0;
                    state_d   = cache_pkg::WR_BURST;
                end else if (bus.read_i) begin
                    addr_d  = aligned_addr;
                    cnt_d   = '0;
                    state_d = cache_pkg::RD_BURST;
                end
            end
            cache_pkg::RD_BURST: begin
                if (bus.resp_i) begin
                    beat_we = 1'b1;
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BEAT) begin
                        state_d = cache_pkg::DONE;
                    end
                end
            end
            cache_pkg::WR_BURST: begin
                if (bus.resp_i) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BEAT) begin
                        state_d = cache_pkg::DONE;
                    end
                end
            end
            cache_pkg::DONE: begin
                state_d = cache_pkg::IDLE;
            end
            default: begin
                state_d = cache_pkg::IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= cache_pkg::IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
        end
    end

    // Reset also clears the buffer so an aborted fill leaves nothing behind.
    line_beat_buffer #(
        .LINE_W (LINE_W),
        .BEAT_W (BEAT_W),
        .CNT_W  (CNT_W)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .load_i    (load_line),
        .line_i    (bus.line_i),
        .beat_we_i (beat_we),
        .slot_i    (cnt_q),
        .beat_i    (bus.burst_i),
        .line_o    (bus.line_o),
        .beat_o    (slot_beat)
    );

    assign bus.read_o    = (state_q == cache_pkg::RD_BURST);
    assign bus.write_o   = (state_q == cache_pkg::WR_BURST);
    assign bus.resp_o    = (state_q == cache_pkg::DONE);
    assign bus.address_o = addr_q;
    assign bus.burst_o   = (state_q == cache_pkg::WR_BURST) ? slot_beat : '0;

`ifdef CACHELINE_ADAPTOR_PERF_EN
    logic        op_wr_q, op_wr_d;
    logic [31:0] fill_cnt_q, fill_cnt_d;
    logic [31:0] wb_cnt_q, wb_cnt_d;

    always_comb begin
        op_wr_d    = op_wr_q;
        fill_cnt_d = fill_cnt_q;
        wb_cnt_d   = wb_cnt_q;
        if (state_q == cache_pkg::IDLE && (bus.write_i || bus.read_i)) begin
            op_wr_d = bus.write_i;
        end
        // Both counters saturate instead of wrapping.
        if (state_q == cache_pkg::DONE) begin
            if (op_wr_q) begin
                if (wb_cnt_q != 32'hFFFF_FFFF) wb_cnt_d = wb_cnt_q + 32'd1;
            end else begin
                if (fill_cnt_q != 32'hFFFF_FFFF) fill_cnt_d = fill_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_wr_q    <= 1'b0;
            fill_cnt_q <= '0;
            wb_cnt_q   <= '0;
        end else begin
            op_wr_q    <= op_wr_d;
            fill_cnt_q <= fill_cnt_d;
            wb_cnt_q   <= wb_cnt_d;
        end
    end

    assign fill_count_o = fill_cnt_q;
    assign wb_count_o   = wb_cnt_q;
`endif

endmodule
